// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state codes and counter sizing.
package serial_sub_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   // Bit counter width: clog2(width), but never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      if (width <= 2)
         return 1;
      return $clog2(width);
   endfunction

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full-subtractor cell: d = a - b - bin, bout = borrow out.
module full_sub_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference and borrow equations of a single subtractor stage.
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~a & bin) | (b & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through a
// single full_sub_bit cell with a registered borrow. start/busy/done handshake.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned    CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic [CW-1:0]    cnt;
   logic             brw;
   logic             d;
   logic             bo;

   full_sub_bit u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (brw),
      .d    (d),
      .bout (bo)
   );

   // Shift the new difference bit in at the MSB; written as shift-or so WIDTH=1 needs no special case.
   always_comb begin
      res_next = (res_sh >> 1) | (WIDTH'(d) << (WIDTH - 1));
   end

   // Status outputs decoded straight from the state register.
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // FSM, operand shift registers, borrow flop and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         cnt        <= '0;
         brw        <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  brw    <= bin;
                  cnt    <= '0;
                  res_sh <= '0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               res_sh <= res_next;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               brw    <= bo;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  diff       <= res_next;
                  borrow_out <= bo;
                  state      <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow_out;

   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       bin1;
   logic       busy1;
   logic       done1;
   logic [0:0] diff1;
   logic       bo1;

   int errors = 0;
   int checks = 0;

   logic [7:0] prev_diff;
   logic       prev_bo;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   vec_t vecs[5];

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
   );

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain modular arithmetic on the 8-bit operands.
   function automatic logic [8:0] ref_sub8(input logic [7:0] x, input logic [7:0] y, input logic c);
      int unsigned xs, ys;
      xs = x;
      ys = int'(y) + int'(c);
      return {(xs < ys), 8'(xs - ys)};
   endfunction

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input logic [7:0] ed, input logic ebo, input bit scramble);
      int cyc;
      bit seen;
      @(negedge clk);
      a = ta; b = tb; bin = tbin; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (scramble) begin
         a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      end
      seen = 0;
      cyc  = 0;
      while (!seen && cyc < 14) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            seen = 1;
            check("latency", 32'(cyc - 1), 32'd8);
            check("busy_at_done", busy, 1);
            check("diff", diff, ed);
            check("borrow_out", borrow_out, ebo);
         end else begin
            check("busy_during", busy, 1);
            check("diff_hold", diff, prev_diff);
            check("bo_hold", borrow_out, prev_bo);
         end
      end
      if (!seen) check("done_timeout", 0, 1);
      @(negedge clk);
      check("busy_after", busy, 0);
      check("done_single", done, 0);
      check("diff_kept", diff, ed);
      prev_diff = ed;
      prev_bo   = ebo;
   endtask

   task automatic run_op1(input logic ta, input logic tb, input logic tbin);
      logic ed, ebo;
      ed  = ta ^ tb ^ tbin;
      ebo = (int'(ta) < int'(tb) + int'(tbin));
      @(negedge clk);
      a1 = ta; b1 = tb; bin1 = tbin; start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      @(negedge clk);
      check("w1_shift_done", done1, 0);
      check("w1_shift_busy", busy1, 1);
      @(negedge clk);
      check("w1_done", done1, 1);
      check("w1_busy_done", busy1, 1);
      check("w1_diff", diff1, ed);
      check("w1_bo", bo1, ebo);
      @(negedge clk);
      check("w1_idle_busy", busy1, 0);
      check("w1_idle_done", done1, 0);
   endtask

   initial begin
      logic [8:0] r;
      logic [7:0] ra, rb;
      logic       rc;
      int         done_at[$];
      int         wait_cyc;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
      prev_diff = '0; prev_bo = 1'b0;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0};
      vecs[4] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};

      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", diff, 0);
      check("rst_bo", borrow_out, 0);
      check("rst_w1_busy", busy1, 0);
      check("rst_w1_diff", diff1, 0);
      rst = 1'b0;

      // Directed vectors; vector 3 scrambles the inputs after acceptance.
      for (int i = 0; i < 5; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, (i == 3));

      // Random operations against the arithmetic reference.
      repeat (25) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         r  = ref_sub8(ra, rb, rc);
         run_op(ra, rb, rc, r[7:0], r[8], 1'($urandom_range(0, 1)));
      end

      // start held high: back-to-back accepts every 10 cycles, one done each.
      @(negedge clk);
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (done) begin
            done_at.push_back(i);
            check("hold_diff", diff, 8'h0F);
            check("hold_bo", borrow_out, 0);
         end
      end
      start = 1'b0;
      check("hold_count", 32'(done_at.size()), 4);
      if (done_at.size() > 0) check("hold_first", 32'(done_at[0]), 8);
      for (int i = 1; i < done_at.size(); i++)
         check("hold_interval", 32'(done_at[i] - done_at[i-1]), 10);
      wait_cyc = 0;
      while (busy && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      check("hold_drain", busy, 0);
      prev_diff = 8'h0F; prev_bo = 1'b0;

      // Reset in the middle of SHIFT: immediate clear, no done.
      @(negedge clk);
      a = 8'hC3; b = 8'h11; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_diff", diff, 0);
      check("abort_bo", borrow_out, 0);
      @(negedge clk);
      rst = 1'b0;
      prev_diff = '0; prev_bo = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
      end
      run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);

      // WIDTH=1: every operand combination.
      for (int i = 0; i < 8; i++)
         run_op1(i[0], i[1], i[2]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor. It computes diff = a - b - bin, LSB first, one bit per clock, through a single one-bit full-subtractor cell with a registered borrow. It sits upstream of the one-bit cell and drives that cell's a/b/borrow inputs, trading the area of a ripple subtractor for WIDTH cycles of latency. A start/busy/done handshake connects it to a sequencing controller.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  minuend; captured on the accepting edge.
b  input  WIDTH  subtrahend; captured on the accepting edge.
bin  input  1  initial borrow, for chaining; captured on the accepting edge.
busy  output  1  high in SHIFT and DONE.
done  output  1  one-cycle pulse when the result is valid.
diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH.
borrow_out  output  1  final borrow; 1 exactly when a < b + bin (unsigned).

Behaviour:
- Reset, asynchronous and active-high:
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, borrow_out = 0.
  - Internal shift registers, borrow flop and counter = 0.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - If start = 1 at an edge: load a_sh <= a, b_sh <= b, brw <= bin, cnt <= 0, res_sh <= 0. Next state is SHIFT.
  - If start = 0: stay in IDLE.
- SHIFT: one bit per edge.
  - Cell inputs are a_sh[0], b_sh[0] and brw.
  - d = a_sh[0] ^ b_sh[0] ^ brw.
  - bo = (!a_sh[0] & b_sh[0]) | (!a_sh[0] & brw) | (b_sh[0] & brw).
  - At the edge: res_sh <= {d, res_sh[WIDTH-1:1]}, a_sh >>= 1, b_sh >>= 1, brw <= bo, cnt <= cnt + 1.
  - When cnt == WIDTH-1 at the edge:
    - diff <= {d, res_sh[WIDTH-1:1]} and borrow_out <= bo, both updated on the same edge.
    - Next state is DONE.
- DONE: done = 1 for exactly this one cycle, then IDLE on the next edge.
- Latency:
  - Start is accepted at edge k.
  - diff, borrow_out and done all become valid after edge k+WIDTH.
  - busy is high from after edge k until after edge k+WIDTH+1.
  - The earliest next accept is edge k+WIDTH+2.
- diff and borrow_out hold their value from the SHIFT→DONE edge until the next completion. They never show partial results.
- start is ignored while busy = 1, including during the DONE cycle. No queuing.
- Changes on a, b or bin after the accepting edge have no effect.
- WIDTH = 1 case: exactly one SHIFT cycle, and the counter is at least 1 bit wide.
- Reset asserted mid-operation:
  - Immediate return to IDLE with every output cleared.
  - No done pulse for the aborted operation.
- All outputs are registered (done decoded from the state register is acceptable). There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package serial_sub_pkg contains:
  - State encoding localparams: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - A helper that computes the counter width as max(1, clog2(WIDTH)).
- One sub-module, full_sub_bit, implements the combinational cell:
  - Ports a, b, bin, d, bout.
  - Equations are as given in SHIFT.
- The FSM, the shift registers and the borrow flop stay in serial_subtractor.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse → done after exactly 8 edges; diff=0x1E, borrow_out=0, busy high for 9 cycles.
2. a=0x00, b=0x01, bin=0 → diff=0xFF, borrow_out=1. Then a=0xFF, b=0xFF, bin=1 → diff=0xFF, borrow_out=1.
3. a=0x80, b=0x00, bin=1 → diff=0x7F, borrow_out=0. Change a and b mid-operation → result is unchanged.
4. Hold start high continuously with a=0x10, b=0x01 → accepts occur every 10 cycles, each yields diff=0x0F, and there is no extra done pulse.
5. Assert rst at SHIFT cycle 4 → outputs go to 0 immediately with no done pulse. A new op after reset, a=0x03, b=0x05, gives diff=0xFE, borrow_out=1.
6. WIDTH=1: 0-1 with bin=0 → diff=1, borrow_out=1, done one edge after accept. 1-0 with bin=1 → diff=0, borrow_out=0.
